perf_counter_port: RTL
======================

Name: perf_counter_port

Overview:
- Synthesizable performance-counter responder for the core; counts cycles, retired instructions and stall cycles.
- Exposes the counts to software or a debug master through a 32-bit read request/response handshake.
- Raises a sticky halted/timeout status and freezes all counts when the core halts or a cycle budget expires.
- Sits beside writeback: consumes the retire valid and halt strobes and serves reads from the load/debug path.

Parameters:
- TIMEOUT, 100000, cycle count at which the watchdog fires; 0 disables the watchdog.
- STALL_W, 32, width of the stall counter; saturates, never wraps.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- W_v  input  1  writeback valid; one retired instruction per cycle it is high
- isHalt  input  1  halt instruction reached writeback
- stall  input  1  pipeline stalled this cycle
- req_v  input  1  read request valid
- req_addr  input  3  counter select
- req_rdy  output  1  request accepted when req_v && req_rdy
- resp_v  output  1  response valid
- resp_data  output  32  response payload
- resp_rdy  input  1  response consumed when resp_v && resp_rdy
- halted  output  1  sticky: isHalt seen
- timeout  output  1  sticky: watchdog fired

Behaviour:
- Reset (async, rst_n low): all counters, both shadow registers, resp_v, resp_data, halted and timeout go to 0. Counting restarts on the first clk edge after release.
- Counters:
  - cycle: 64 bit, +1 every clk while not frozen.
  - instret: 64 bit, +1 when W_v while not frozen.
  - stallcnt: STALL_W bits, +1 when stall while not frozen; holds at all-ones.
- Frozen = halted || timeout.
  - On the isHalt cycle, W_v and stall of that same cycle are still counted; halted=1 from the next cycle.
- Watchdog: when TIMEOUT!=0, not frozen, and cycle==TIMEOUT-1 at a clk edge:
  - cycle becomes TIMEOUT and timeout=1 on that edge.
  - If isHalt is high in that same cycle, both halted and timeout set.
- Address map:
  - 0 cycle[31:0]; also latches cycle[63:32] into cyc_shadow.
  - 1 cyc_shadow.
  - 2 instret[31:0]; also latches instret[63:32] into ins_shadow.
  - 3 ins_shadow.
  - 4 stallcnt, zero-extended to 32 bits.
  - 5 status {30'b0, timeout, halted}.
  - 6 constant 32'h0000_0000.
  - 7 reserved, reads 0 (see Optional Feature).
- Sampling: values are sampled at the accepting edge, i.e. before that edge's own increment.
- Handshake:
  - One-entry response buffer; req_rdy = !resp_v || resp_rdy (combinational).
  - Accepted request: resp_v=1 and resp_data loaded on the next edge, giving 1-cycle latency.
  - resp_v and resp_data hold stable until resp_rdy. Back-to-back accept with resp_rdy tied high gives 1 response per cycle.
  - resp_v drops on a consume edge with no new accept.
- Reads never stall counting. Reads stay serviced while frozen and return the frozen values.
- Shadow registers change only on reads of addr 0/2, so an addr-1 read without a prior addr-0 read returns the stale/reset shadow.

Optional Feature:
- Macro PERF_COUNTER_CLEAR_EN.
- Defined: a read of addr 7 returns 32'h0 and, on the accepting edge, clears cycle, instret, stallcnt, both shadows, halted and timeout. A clear has priority over same-edge increments and over setting halted/timeout.
- Undefined: addr 7 is a plain read of 0 with no side effect, and counters are cleared only by rst_n.

Test Plan:
- Reset, then 10 cycles with W_v high on 4 of them, then read addr 0 then addr 2 → resp_data=10 (cycle sampled at its accepting edge, which is the 11th clk after reset release) and then 4. Each response arrives exactly 1 cycle after accept.
- TIMEOUT=20, no isHalt → timeout=1 after the 20th edge. A later read of addr 0 returns 20 and addr 5 returns 32'h2; cycle stays at 20 thereafter.
- Pulse isHalt together with W_v at instret=7 → instret reads 8, halted=1, status=32'h1. Further W_v pulses do not change instret.
- Force cycle to 32'hFFFF_FFFF via 2^32 cycles (or a bench preload) → addr 0 reads 0, then addr 1 reads 1, confirming the carry and the shadow latch.
- Hold resp_rdy low for 3 cycles with req_v high → req_rdy=0, resp_data unchanged. Release → one response consumed and the next request accepted on the same edge.
- With PERF_COUNTER_CLEAR_EN: after 50 cycles read addr 7 → resp 0; a subsequent addr 0 read returns the number of cycles since the clear. Without the macro, the same addr 7 read leaves the count continuing from 50.

Source files
------------

// File: rtl/perf_counter_port.sv
// Performance counters (cycles, retired instructions, stall cycles) served over a 32-bit read handshake.
// Optional macro PERF_COUNTER_CLEAR_EN: a read of address 7 clears all counts, shadows and status.
module perf_counter_port #(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned STALL_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        W_v,
  input  logic        isHalt,
  input  logic        stall,
  input  logic        req_v,
  input  logic [2:0]  req_addr,
  output logic        req_rdy,
  output logic        resp_v,
  output logic [31:0] resp_data,
  input  logic        resp_rdy,
  output logic        halted,
  output logic        timeout
);

  localparam logic [63:0] WD_LAST = 64'(TIMEOUT) - 64'd1;

  logic [63:0]        cycle;
  logic [63:0]        instret;
  logic [STALL_W-1:0] stallcnt;
  logic [31:0]        cyc_shadow;
  logic [31:0]        ins_shadow;
  logic [31:0]        stall_ext;
  logic [31:0]        rd_mux;
  logic               frozen;
  logic               accept;
  logic               wd_fire;
  logic               clear;
  logic               stall_sat;

  assign frozen    = halted | timeout;
  assign req_rdy   = !resp_v || resp_rdy;
  assign accept    = req_v && req_rdy;
  assign stall_sat = &stallcnt;
  assign wd_fire   = (TIMEOUT != 0) && !frozen && (cycle == WD_LAST);

`ifdef PERF_COUNTER_CLEAR_EN
  assign clear = accept && (req_addr == 3'd7);
`else
  assign clear = 1'b0;
`endif

  generate
    if (STALL_W >= 32) begin : g_stall_trunc
      assign stall_ext = stallcnt[31:0];
    end else begin : g_stall_pad
      assign stall_ext = {{(32-STALL_W){1'b0}}, stallcnt};
    end
  endgenerate

  // Read values are taken from the current register state, i.e. before this edge's increment.
  always_comb begin
    rd_mux = 32'h0;
    case (req_addr)
      3'd0:    rd_mux = cycle[31:0];
      3'd1:    rd_mux = cyc_shadow;
      3'd2:    rd_mux = instret[31:0];
      3'd3:    rd_mux = ins_shadow;
      3'd4:    rd_mux = stall_ext;
      3'd5:    rd_mux = {30'b0, timeout, halted};
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle    <= '0;
      instret  <= '0;
      stallcnt <= '0;
    end else if (clear) begin
      cycle    <= '0;
      instret  <= '0;
      stallcnt <= '0;
    end else if (!frozen) begin
      cycle <= cycle + 64'd1;
      if (W_v)
        instret <= instret + 64'd1;
      if (stall && !stall_sat)
        stallcnt <= stallcnt + STALL_W'(1);
    end
  end

  // Halt and watchdog on the same edge both latch; the halting cycle itself is still counted above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted  <= 1'b0;
      timeout <= 1'b0;
    end else if (clear) begin
      halted  <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (isHalt)
        halted <= 1'b1;
      if (wd_fire)
        timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_shadow <= '0;
      ins_shadow <= '0;
    end else if (clear) begin
      cyc_shadow <= '0;
      ins_shadow <= '0;
    end else if (accept) begin
      if (req_addr == 3'd0)
        cyc_shadow <= cycle[63:32];
      if (req_addr == 3'd2)
        ins_shadow <= instret[63:32];
    end
  end

  // One-entry response buffer: payload holds until consumed, a new accept may refill it on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_v    <= 1'b0;
      resp_data <= '0;
    end else if (accept) begin
      resp_v    <= 1'b1;
      resp_data <= rd_mux;
    end else if (resp_rdy) begin
      resp_v <= 1'b0;
    end
  end

endmodule
